// File: rtl/psram_qspi_responder.sv
// SPI/QPI PSRAM device model on HCLK: oversamples sck/ce_n/io_in, decodes commands and serves
// reads and writes from an internal byte array while tracking QPI mode.
`timescale 1ns / 1ps
module psram_qspi_responder #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] io_in,
  input  logic [3:0] wait_cycles,
  output logic [3:0] io_out,
  output logic [3:0] io_oe,
  output logic       qpi_mode,
  output logic       busy,
  output logic       cmd_err
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StRd, StWr, StIgnore} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sck_sync_q, ce_sync_q;
  logic            sck_prev_q, ce_prev_q;
  logic [3:0]      io_s1_q, io_s2_q;
  logic [4:0]      cnt_q, cnt_d;
  logic [23:0]     shift_q, shift_d, shift_in;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [7:0]      tx_q, tx_d, byte_rd;
  logic [3:0]      io_out_q, io_out_d, io_oe_q, io_oe_d;
  logic            qpi_q, qpi_d, cmd_err_q, cmd_err_d;
  logic            rd_q, rd_d, addr_quad_q, addr_quad_d, data_quad_q, data_quad_d;
  logic            dummy_q, dummy_d, pend_set_q, pend_set_d, pend_clr_q, pend_clr_d;
  logic            mem_we, quad_now;
  logic            op_ok, op_rd, op_qaddr, op_qdata, op_dummy, op_set, op_clr;
  logic [7:0]      mem [DEPTH];

  logic sck_s, ce_s, rise, fall, ce_rise, ce_fall;
  logic cmd_last, addr_last, dummy_last, byte_last;

  assign sck_s   = sck_sync_q[1];
  assign ce_s    = ce_sync_q[1];
  // sck edges only count while the synchronized chip enable is low
  assign rise    = sck_s & ~sck_prev_q & ~ce_s;
  assign fall    = ~sck_s & sck_prev_q & ~ce_s;
  assign ce_rise = ce_s & ~ce_prev_q;
  assign ce_fall = ~ce_s & ce_prev_q;

  assign quad_now  = (state_q == StCmd) ? qpi_q : (state_q == StAddr) ? addr_quad_q : data_quad_q;
  assign shift_in  = quad_now ? {shift_q[19:0], io_s2_q} : {shift_q[22:0], io_s2_q[0]};
  assign cmd_last  = qpi_q ? (cnt_q == 5'd1) : (cnt_q == 5'd7);
  assign addr_last = addr_quad_q ? (cnt_q == 5'd5) : (cnt_q == 5'd23);
  assign dummy_last = (cnt_q == ({1'b0, wait_cycles} - 5'd1));
  assign byte_last = data_quad_q ? (cnt_q == 5'd1) : (cnt_q == 5'd7);
  assign byte_rd   = (cnt_q == 5'd0) ? mem[ptr_q] : tx_q;

  always_comb begin
    op_ok    = 1'b1;
    op_rd    = 1'b0;
    op_qaddr = qpi_q;
    op_qdata = qpi_q;
    op_dummy = 1'b0;
    op_set   = 1'b0;
    op_clr   = 1'b0;
    if (!qpi_q) begin
      case (shift_in[7:0])
        8'h03: op_rd = 1'b1;
        8'h02: ;
        8'hEB: begin op_rd = 1'b1; op_qaddr = 1'b1; op_qdata = 1'b1; op_dummy = 1'b1; end
        8'h38: begin op_qaddr = 1'b1; op_qdata = 1'b1; end
        8'h35: op_set = 1'b1;
        default: op_ok = 1'b0;
      endcase
    end else begin
      case (shift_in[7:0])
        8'hEB: begin op_rd = 1'b1; op_dummy = 1'b1; end
        8'h03: op_rd = 1'b1;
        8'h02, 8'h38: ;
        8'hF5: op_clr = 1'b1;
        default: op_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ce_rise) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (ce_fall) state_d = StCmd;
        StCmd:   if (rise && cmd_last) begin
          state_d = (!op_ok || op_set || op_clr) ? StIgnore : StAddr;
        end
        StAddr:  if (rise && addr_last) begin
          if (dummy_q && wait_cycles != 4'd0) state_d = StDummy;
          else                                state_d = rd_q ? StRd : StWr;
        end
        StDummy: if (rise && dummy_last) state_d = StRd;
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    tx_d        = tx_q;
    io_out_d    = io_out_q;
    io_oe_d     = io_oe_q;
    qpi_d       = qpi_q;
    cmd_err_d   = 1'b0;
    rd_d        = rd_q;
    addr_quad_d = addr_quad_q;
    data_quad_d = data_quad_q;
    dummy_d     = dummy_q;
    pend_set_d  = pend_set_q;
    pend_clr_d  = pend_clr_q;
    mem_we      = 1'b0;
    if (ce_rise) begin
      io_out_d   = 4'h0;
      io_oe_d    = 4'h0;
      cnt_d      = 5'd0;
      // pending flags are only armed once the whole command was clocked in
      if (pend_set_q) qpi_d = 1'b1;
      if (pend_clr_q) qpi_d = 1'b0;
      pend_set_d = 1'b0;
      pend_clr_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: if (ce_fall) begin
          cnt_d   = 5'd0;
          shift_d = 24'h0;
        end
        StCmd: if (rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 5'd1;
          if (cmd_last) begin
            cnt_d       = 5'd0;
            rd_d        = op_rd;
            addr_quad_d = op_qaddr;
            data_quad_d = op_qdata;
            dummy_d     = op_dummy;
            cmd_err_d   = ~op_ok;
            pend_set_d  = op_set;
            pend_clr_d  = op_clr;
          end
        end
        StAddr: if (rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 5'd1;
          if (addr_last) begin
            cnt_d = 5'd0;
            ptr_d = shift_in[AW-1:0];
          end
        end
        StDummy: if (rise) cnt_d = dummy_last ? 5'd0 : cnt_q + 5'd1;
        StRd: if (fall) begin
          if (cnt_q == 5'd0) ptr_d = ptr_q + AW'(1);
          cnt_d = byte_last ? 5'd0 : cnt_q + 5'd1;
          if (data_quad_q) begin
            io_out_d = byte_rd[7:4];
            io_oe_d  = 4'b1111;
            tx_d     = {byte_rd[3:0], 4'h0};
          end else begin
            io_out_d = {2'b00, byte_rd[7], 1'b0};
            io_oe_d  = 4'b0010;
            tx_d     = {byte_rd[6:0], 1'b0};
          end
        end
        StWr: if (rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 5'd1;
          if (byte_last) begin
            cnt_d  = 5'd0;
            mem_we = 1'b1;
            ptr_d  = ptr_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sck_sync_q  <= 2'b00;
      sck_prev_q  <= 1'b0;
      ce_sync_q   <= 2'b11;
      ce_prev_q   <= 1'b1;
      io_s1_q     <= 4'h0;
      io_s2_q     <= 4'h0;
      cnt_q       <= 5'd0;
      shift_q     <= 24'h0;
      ptr_q       <= '0;
      tx_q        <= 8'h0;
      io_out_q    <= 4'h0;
      io_oe_q     <= 4'h0;
      qpi_q       <= 1'b0;
      cmd_err_q   <= 1'b0;
      rd_q        <= 1'b0;
      addr_quad_q <= 1'b0;
      data_quad_q <= 1'b0;
      dummy_q     <= 1'b0;
      pend_set_q  <= 1'b0;
      pend_clr_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck};
      sck_prev_q  <= sck_s;
      ce_sync_q   <= {ce_sync_q[0], ce_n};
      ce_prev_q   <= ce_s;
      io_s1_q     <= io_in;
      io_s2_q     <= io_s1_q;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      tx_q        <= tx_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
      qpi_q       <= qpi_d;
      cmd_err_q   <= cmd_err_d;
      rd_q        <= rd_d;
      addr_quad_q <= addr_quad_d;
      data_quad_q <= data_quad_d;
      dummy_q     <= dummy_d;
      pend_set_q  <= pend_set_d;
      pend_clr_q  <= pend_clr_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive HRESETn.
  always_ff @(posedge HCLK) begin
    if (mem_we) mem[ptr_q] <= shift_in[7:0];
  end

  assign io_out   = io_out_q;
  assign io_oe    = io_oe_q;
  assign qpi_mode = qpi_q;
  assign busy     = ~ce_s;
  assign cmd_err  = cmd_err_q;
endmodule
